// File: rtl/ringbuffer_flags.sv
// ringbuffer_flags
//   Parametrised synchronous ring-buffer FIFO. It has a first-word-fall-through
//   read port, a fill level, almost-full and almost-empty flags, and peak-level
//   (high-water) tracking. It sits between the AXI-Lite master FSM and its
//   command/response producers and consumers. All DEPTH entries are usable, and
//   DEPTH does not need to be a power of two.
//
// Parameters
//   DEPTH     number of storage entries (>= 2)
//   DATA_W    entry width in bits
//   AF_LEVEL  almost_full when level >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL  almost_empty when level <= AE_LEVEL (0..DEPTH-1)
//
// Ports
//   clk           single clock, everything on posedge
//   resetn        synchronous active-low reset (clears pointers, level, peak)
//   flush         synchronous clear of contents; the storage RAM is untouched
//   s_valid       write request
//   s_ready       space available (level < DEPTH)
//   s_data        write data
//   m_valid       head entry valid (level != 0)
//   m_ready       consumer accepts the head entry
//   m_data        head entry, first-word-fall-through
//   level         current occupancy, 0..DEPTH
//   peak_level    maximum level since reset, flush or peak_clr
//   peak_clr      reload peak_level with the next level
//   almost_full   level >= AF_LEVEL
//   almost_empty  level <= AE_LEVEL
module ringbuffer_flags #(
  parameter int DEPTH    = 16,
  parameter int DATA_W   = 32,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 2,
  localparam int LW      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [LW-1:0]     level,
  output logic [LW-1:0]     peak_level,
  input  logic              peak_clr,
  output logic              almost_full,
  output logic              almost_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Reject parameter combinations that make the flags or storage meaningless.
  if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
      AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_paramCheck
    $error("ringbuffer_flags: illegal parameters DEPTH=%0d AF_LEVEL=%0d AE_LEVEL=%0d",
           DEPTH, AF_LEVEL, AE_LEVEL);
  end

  logic [DATA_W-1:0] r_ram [DEPTH];
  logic [PW-1:0]     r_wrPtr;
  logic [PW-1:0]     r_rdPtr;
  logic [LW-1:0]     r_level;
  logic [LW-1:0]     r_peak;

  logic              w_push;
  logic              w_pop;
  logic [PW-1:0]     w_wrPtrNext;
  logic [PW-1:0]     w_rdPtrNext;
  logic [LW-1:0]     w_nextLevel;
  logic [LW-1:0]     w_nextPeak;

  // Handshake outputs depend only on the registered level. This keeps s_ready
  // independent of m_ready, so a full FIFO refuses a push even while it pops.
  assign s_ready      = (r_level != LW'(DEPTH));
  assign m_valid      = (r_level != '0);
  assign w_push       = s_valid & s_ready;
  assign w_pop        = m_valid & m_ready;
  assign m_data       = r_ram[r_rdPtr];
  assign level        = r_level;
  assign peak_level   = r_peak;
  assign almost_full  = (r_level >= LW'(AF_LEVEL));
  assign almost_empty = (r_level <= LW'(AE_LEVEL));

  // Pointer increment with an explicit wrap at DEPTH-1. This works when DEPTH
  // is not a power of two, where wrapping on the pointer width would be wrong.
  always_comb begin
    w_wrPtrNext = (r_wrPtr == PW'(DEPTH - 1)) ? '0 : r_wrPtr + PW'(1);
    w_rdPtrNext = (r_rdPtr == PW'(DEPTH - 1)) ? '0 : r_rdPtr + PW'(1);
  end

  // Next level from the push/pop pair. The peak follows the running maximum,
  // or is reloaded with the new level when peak_clr is set.
  always_comb begin
    w_nextLevel = r_level;
    case ({w_push, w_pop})
      2'b10:   w_nextLevel = r_level + LW'(1);
      2'b01:   w_nextLevel = r_level - LW'(1);
      default: w_nextLevel = r_level;
    endcase
    w_nextPeak = r_peak;
    if (peak_clr) begin
      w_nextPeak = w_nextLevel;
    end else if (w_nextLevel > r_peak) begin
      w_nextPeak = w_nextLevel;
    end
  end

  // Control state. Reset beats flush, and flush beats any push, pop or peak_clr.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_peak  <= '0;
    end else if (flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
      r_peak  <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= w_wrPtrNext;
      end
      if (w_pop) begin
        r_rdPtr <= w_rdPtrNext;
      end
      r_level <= w_nextLevel;
      r_peak  <= w_nextPeak;
    end
  end

  // Storage has no reset. A push discarded by reset or flush is never written.
  // While the FIFO is neither empty nor full, the write slot differs from the
  // read slot, so a simultaneous push cannot disturb the head entry.
  always_ff @(posedge clk) begin
    if (resetn && !flush && w_push) begin
      r_ram[r_wrPtr] <= s_data;
    end
  end

endmodule

// File: tb/tb_ringbuffer_flags.sv
// tb_ringbuffer_flags
//   Directed bench for ringbuffer_flags with DEPTH=5, DATA_W=8, AF_LEVEL=4 and
//   AE_LEVEL=1. A vector table covers reset, fill, drain and full-with-pop.
//   Hand-written sequences then cover wrap with simultaneous push/pop, flush
//   while pushing, a mid-fill reset, and peak_clr.
module tb_ringbuffer_flags;

  localparam int LW = 3;

  logic       clk;
  logic       resetn;
  logic       flush;
  logic       sValid;
  logic       sReady;
  logic [7:0] sData;
  logic       mValid;
  logic       mReady;
  logic [7:0] mData;
  logic [LW-1:0] level;
  logic [LW-1:0] peakLevel;
  logic       peakClr;
  logic       almostFull;
  logic       almostEmpty;

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    logic       sv;
    logic       mr;
    logic [7:0] d;
    logic [2:0] lvl;
    logic       mv;
    logic       sr;
    logic       af;
    logic       ae;
    logic [2:0] pk;
    logic       chkData;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[$];
  logic [7:0] model[$];

  ringbuffer_flags #(
    .DEPTH(5), .DATA_W(8), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .s_valid(sValid), .s_ready(sReady), .s_data(sData),
    .m_valid(mValid), .m_ready(mReady), .m_data(mData),
    .level(level), .peak_level(peakLevel), .peak_clr(peakClr),
    .almost_full(almostFull), .almost_empty(almostEmpty)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation and count it.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checksTotal++;
    if (act === exp) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and leave time at #1 past the edge.
  task automatic applyStimulus(input logic rn, input logic fl, input logic sv,
                               input logic mr, input logic [7:0] d,
                               input logic pc);
    resetn  = rn;
    flush   = fl;
    sValid  = sv;
    mReady  = mr;
    sData   = d;
    peakClr = pc;
    @(posedge clk);
    #1;
  endtask

  // Check the status outputs that most hand-written steps look at.
  task automatic checkStatus(input string tag, input int lvl, input logic mv,
                             input int pk);
    checkOutput({tag, " level"}, 32'(level), 32'(lvl));
    checkOutput({tag, " m_valid"}, 32'(mValid), 32'(mv));
    checkOutput({tag, " peak"}, 32'(peakLevel), 32'(pk));
  endtask

  initial begin
    resetn = 1'b0; flush = 1'b0; sValid = 1'b0; mReady = 1'b0;
    sData = 8'h00; peakClr = 1'b0;

    // sv mr data | lvl mv sr af ae pk | chk expData
    // Idle after reset.
    vecs.push_back('{1'b0,1'b0,8'h00, 3'd0,1'b0,1'b1,1'b0,1'b1,3'd0, 1'b0,8'h00});
    // Fill A0..A4, then a sixth push that must not be stored.
    vecs.push_back('{1'b1,1'b0,8'hA0, 3'd1,1'b1,1'b1,1'b0,1'b1,3'd1, 1'b1,8'hA0});
    vecs.push_back('{1'b1,1'b0,8'hA1, 3'd2,1'b1,1'b1,1'b0,1'b0,3'd2, 1'b1,8'hA0});
    vecs.push_back('{1'b1,1'b0,8'hA2, 3'd3,1'b1,1'b1,1'b0,1'b0,3'd3, 1'b1,8'hA0});
    vecs.push_back('{1'b1,1'b0,8'hA3, 3'd4,1'b1,1'b1,1'b1,1'b0,3'd4, 1'b1,8'hA0});
    vecs.push_back('{1'b1,1'b0,8'hA4, 3'd5,1'b1,1'b0,1'b1,1'b0,3'd5, 1'b1,8'hA0});
    vecs.push_back('{1'b1,1'b0,8'hA5, 3'd5,1'b1,1'b0,1'b1,1'b0,3'd5, 1'b1,8'hA0});
    // Drain. The head after each pop is the next word in order.
    vecs.push_back('{1'b0,1'b1,8'h00, 3'd4,1'b1,1'b1,1'b1,1'b0,3'd5, 1'b1,8'hA1});
    vecs.push_back('{1'b0,1'b1,8'h00, 3'd3,1'b1,1'b1,1'b0,1'b0,3'd5, 1'b1,8'hA2});
    vecs.push_back('{1'b0,1'b1,8'h00, 3'd2,1'b1,1'b1,1'b0,1'b0,3'd5, 1'b1,8'hA3});
    vecs.push_back('{1'b0,1'b1,8'h00, 3'd1,1'b1,1'b1,1'b0,1'b1,3'd5, 1'b1,8'hA4});
    vecs.push_back('{1'b0,1'b1,8'h00, 3'd0,1'b0,1'b1,1'b0,1'b1,3'd5, 1'b0,8'h00});
    // A pop request on an empty FIFO does nothing.
    vecs.push_back('{1'b0,1'b1,8'h00, 3'd0,1'b0,1'b1,1'b0,1'b1,3'd5, 1'b0,8'h00});
    // Refill B0..B4 to full, then push+pop while full: pop only.
    vecs.push_back('{1'b1,1'b0,8'hB0, 3'd1,1'b1,1'b1,1'b0,1'b1,3'd5, 1'b1,8'hB0});
    vecs.push_back('{1'b1,1'b0,8'hB1, 3'd2,1'b1,1'b1,1'b0,1'b0,3'd5, 1'b1,8'hB0});
    vecs.push_back('{1'b1,1'b0,8'hB2, 3'd3,1'b1,1'b1,1'b0,1'b0,3'd5, 1'b1,8'hB0});
    vecs.push_back('{1'b1,1'b0,8'hB3, 3'd4,1'b1,1'b1,1'b1,1'b0,3'd5, 1'b1,8'hB0});
    vecs.push_back('{1'b1,1'b0,8'hB4, 3'd5,1'b1,1'b0,1'b1,1'b0,3'd5, 1'b1,8'hB0});
    vecs.push_back('{1'b1,1'b1,8'hB5, 3'd4,1'b1,1'b1,1'b1,1'b0,3'd5, 1'b1,8'hB1});

    // Hold reset for two edges.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    checkStatus("reset", 0, 1'b0, 0);
    checkOutput("reset s_ready", 32'(sReady), 32'd1);
    checkOutput("reset almost_empty", 32'(almostEmpty), 32'd1);
    checkOutput("reset almost_full", 32'(almostFull), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1'b1, 1'b0, vecs[i].sv, vecs[i].mr, vecs[i].d, 1'b0);
      checkOutput($sformatf("row%0d level", i), 32'(level), 32'(vecs[i].lvl));
      checkOutput($sformatf("row%0d m_valid", i), 32'(mValid), 32'(vecs[i].mv));
      checkOutput($sformatf("row%0d s_ready", i), 32'(sReady), 32'(vecs[i].sr));
      checkOutput($sformatf("row%0d almost_full", i), 32'(almostFull), 32'(vecs[i].af));
      checkOutput($sformatf("row%0d almost_empty", i), 32'(almostEmpty), 32'(vecs[i].ae));
      checkOutput($sformatf("row%0d peak", i), 32'(peakLevel), 32'(vecs[i].pk));
      if (vecs[i].chkData) begin
        checkOutput($sformatf("row%0d m_data", i), 32'(mData), 32'(vecs[i].expData));
      end
    end

    // Flush to empty, preload two words, then run 20 cycles of push and pop
    // together. The pointers wrap several times while the level stays at 2.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    checkStatus("flush4", 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hC0, 1'b0);
    model.push_back(8'hC0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hC1, 1'b0);
    model.push_back(8'hC1);
    checkOutput("wrap preload level", 32'(level), 32'd2);
    for (int i = 0; i < 20; i++) begin
      checkOutput($sformatf("wrap%0d m_data", i), 32'(mData), 32'(model[0]));
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 8'(8'h10 + i), 1'b0);
      void'(model.pop_front());
      model.push_back(8'(8'h10 + i));
      checkOutput($sformatf("wrap%0d level", i), 32'(level), 32'd2);
    end
    while (model.size() > 0) begin
      checkOutput("wrap drain m_data", 32'(mData), 32'(model[0]));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
      void'(model.pop_front());
    end
    checkStatus("wrap end", 0, 1'b0, 2);

    // Flush at level 3 while a push is offered. The pushed word must vanish.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hE0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hE1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hE2, 1'b0);
    checkStatus("pre-flush", 3, 1'b1, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hEE, 1'b0);
    checkStatus("flush6", 0, 1'b0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hF0, 1'b0);
    checkStatus("post-flush push", 1, 1'b1, 1);
    checkOutput("post-flush m_data", 32'(mData), 32'h0F0);

    // Reset in the middle of a fill while a push is offered.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hF1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'hF2, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 1'b0);
    checkStatus("midreset", 0, 1'b0, 0);
    checkOutput("midreset s_ready", 32'(sReady), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0);
    checkStatus("post-reset push", 1, 1'b1, 1);
    checkOutput("post-reset m_data", 32'(mData), 32'h055);

    // peak_clr reloads the peak with the new level instead of keeping the max.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 8'h56, 1'b0);
    checkStatus("peak grow", 2, 1'b1, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1);
    checkStatus("peak_clr", 1, 1'b1, 1);
    checkOutput("peak_clr m_data", 32'(mData), 32'h056);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
